rtib_core: RTL and testbench
============================

RTIB_CORE -- requirements
Module: rtib_core

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as follows.
  THRESHOLD  1000  occupancy at which full asserts and new events are dropped.
  DEPTH  1024  FIFO entries.
  ADDR_LEN  10  FIFO pointer width, log2(DEPTH).
  DATA_LEN  8  monitored input lines.
REQ-002 Ports (name, direction, width, meaning) SHALL be as follows.
  clk  in  1  sole clock.
  reset_n  in  1  asynchronous, active-low reset.
  auto_start  in  1  capture enable.
  flush  in  1  synchronous clear.
  data_in  in  DATA_LEN  monitored lines.
  counter  in  64  global timestamp counter.
  read  in  1  pop request.
  rtib_out  out  128  {timestamp[63:0], zeros, data[DATA_LEN-1:0]}.
  out_valid  out  1  one-cycle pulse when rtib_out updates.
  overflow_error  out  1  event dropped.
  overflow_error_data  out  128  last dropped event.
  underflow_error  out  1  read while empty.
  full  out  1  FIFO occupancy >= THRESHOLD.
  empty  out  1  FIFO occupancy == 0.

Function
REQ-003 The block SHALL register the sample each cycle into prev_data; event = auto_start && (sample != prev_data).
REQ-004 The block SHALL form an event entry {counter, data} from the counter value of the cycle in which the change is sampled.
REQ-005 The block SHALL write an event to the FIFO only when ~full, with write-to-~empty latency of 1 cycle.
REQ-006 An event occurring while full SHALL be dropped; overflow_error SHALL pulse high the next cycle and overflow_error_data SHALL latch {timestamp, zeros, data}.
REQ-007 read && ~empty SHALL pop the head entry; rtib_out SHALL be registered and out_valid SHALL pulse 1 cycle after read.
REQ-008 read && empty SHALL leave rtib_out unchanged, hold out_valid low, and pulse underflow_error the next cycle.
REQ-009 With simultaneous write and pop, occupancy SHALL be unchanged; full SHALL be evaluated on occupancy before the pop.
REQ-010 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be an ADDR_LEN+1-bit count.
REQ-011 When auto_start is low, no events SHALL be captured, prev_data SHALL still track the sample, and reads SHALL proceed.
REQ-012 flush SHALL empty the FIFO, clear all error outputs, zero rtib_out and overflow_error_data, and set prev_data to the current sample; flush SHALL take priority over same-cycle event and read.

Reset
REQ-013 While reset_n is low, all registers SHALL clear asynchronously: rtib_out=0, out_valid=0, overflow_error=0, underflow_error=0, overflow_error_data=0, prev_data=0, pointers=0, empty=1, full=0.
REQ-014 Reset deassertion mid-operation SHALL discard all stored events.
REQ-015 Reset deassertion SHALL be synchronised to clk before reaching the FIFO pointers.

Configuration
REQ-016 The macro RTIB_INPUT_SYNC_EN SHALL, when defined, route data_in through a 2-flop synchroniser and stamp events with counter-2, so that timestamps match the unsynchronised build.
REQ-017 When RTIB_INPUT_SYNC_EN is undefined, data_in SHALL be sampled directly and stamped with counter.

Structure
REQ-018 A shared package rtib_pkg SHALL hold the event entry typedef {timestamp[63:0], data}, the 128-bit output packing function, and the default parameter constants.
REQ-019 The FIFO storage SHALL be one sub-module, rtib_fifo, a synchronous RAM with occupancy count and full/empty flags.

Verification
REQ-020 Verification SHALL cover the following directed scenarios.
  - auto_start=1, data_in 0x00->0x05 at counter=100, then read -> out_valid one cycle later, rtib_out={64'd100, 56'h0, 8'h05}.
  - data_in held at 0x05 for 50 cycles -> no writes, empty stays 1.
  - 1000 events without reads -> full=1; 1001st event at counter=2000 with data 0xAA -> overflow_error pulse, overflow_error_data={64'd2000, 56'h0, 8'hAA}, occupancy stays 1000.
  - read while empty -> underflow_error pulse, out_valid=0, rtib_out unchanged.
  - 3 events, flush, then read -> empty=1, underflow_error pulse, all outputs zero.
  - reset_n low for 1 cycle during a read burst -> all outputs at reset values immediately; no stale data after release.

Source files
------------

// File: rtl/rtib_pkg.sv
// rtib_pkg: shared constants, event entry type and output packing for the
// real-time input buffer (rtib_core / rtib_fifo).
package rtib_pkg;

  localparam int RTIB_THRESHOLD = 1000;
  localparam int RTIB_DEPTH     = 1024;
  localparam int RTIB_ADDR_LEN  = 10;
  localparam int RTIB_DATA_LEN  = 8;

  // One captured event at the default data width.
  typedef struct packed {
    logic [63:0]              timestamp;
    logic [RTIB_DATA_LEN-1:0] data;
  } rtib_entry_t;

  // 128-bit external format: {timestamp, zero-extended data}.
  function automatic logic [127:0] rtib_pack(input logic [63:0] ts,
                                             input logic [63:0] data_zx);
    return {ts, data_zx};
  endfunction

endpackage

// File: rtl/rtib_fifo.sv
// rtib_fifo: synchronous-write RAM FIFO with occupancy count, full at
// THRESHOLD, registered read data and a one-cycle read-valid pulse.
// Flush clears pointers, count and read data and wins over write/read.
module rtib_fifo #(
  parameter int DEPTH     = 1024,
  parameter int ADDR_LEN  = 10,
  parameter int WIDTH     = 72,
  parameter int THRESHOLD = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_flush,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic             o_full,
  output logic             o_empty
);

  localparam int CNT_W = ADDR_LEN + 1;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [ADDR_LEN-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                w_wr, w_rd;

  // Full is judged on occupancy before any same-cycle pop.
  assign o_full  = (r_count >= CNT_W'(THRESHOLD));
  assign o_empty = (r_count == '0);
  assign w_wr    = i_wr & ~o_full  & ~i_flush;
  assign w_rd    = i_rd & ~o_empty & ~i_flush;

  // Storage write; no reset so the array can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers wrap naturally at DEPTH; count tracks net occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + ADDR_LEN'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + ADDR_LEN'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered head read; data holds when no pop occurs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else if (i_flush) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= w_rd;
      if (w_rd) o_rd_data <= r_mem[r_rd_ptr];
    end
  end

endmodule

// File: rtl/rtib_core.sv
// rtib_core: timestamps changes on data_in into a FIFO and serves them on
// read as 128-bit words. Define RTIB_INPUT_SYNC_EN to pass data_in through
// a 2-flop synchroniser (timestamps are compensated by 2 cycles).
module rtib_core import rtib_pkg::*; #(
  parameter int THRESHOLD = RTIB_THRESHOLD,
  parameter int DEPTH     = RTIB_DEPTH,
  parameter int ADDR_LEN  = RTIB_ADDR_LEN,
  parameter int DATA_LEN  = RTIB_DATA_LEN
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                auto_start,
  input  logic                flush,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic [63:0]         counter,
  input  logic                read,
  output logic [127:0]        rtib_out,
  output logic                out_valid,
  output logic                overflow_error,
  output logic [127:0]        overflow_error_data,
  output logic                underflow_error,
  output logic                full,
  output logic                empty
);

  localparam int ENT_W = 64 + DATA_LEN;

  logic [1:0]          r_rst_sync;
  logic                w_rst_n;
  logic [DATA_LEN-1:0] w_sample, r_prev_data;
  logic [63:0]         w_stamp;
  logic                w_event, w_overflow, w_underflow;
  logic [ENT_W-1:0]    w_rd_data;

  // Async assert, clock-synchronised release of the internal reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

`ifdef RTIB_INPUT_SYNC_EN
  logic [DATA_LEN-1:0] r_sync1, r_sync2;

  // Two-flop synchroniser for asynchronous input lines.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= data_in;
      r_sync2 <= r_sync1;
    end
  end
  assign w_sample = r_sync2;
  // Sample is two cycles old; back-date the stamp to match the raw build.
  assign w_stamp  = counter - 64'd2;
`else
  assign w_sample = data_in;
  assign w_stamp  = counter;
`endif

  assign w_event     = auto_start && (w_sample != r_prev_data);
  assign w_overflow  = w_event && full && !flush;
  assign w_underflow = read && empty && !flush;

  rtib_fifo #(
    .DEPTH     (DEPTH),
    .ADDR_LEN  (ADDR_LEN),
    .WIDTH     (ENT_W),
    .THRESHOLD (THRESHOLD)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (w_rst_n),
    .i_flush    (flush),
    .i_wr       (w_event),
    .i_wr_data  ({w_stamp, w_sample}),
    .i_rd       (read),
    .o_rd_data  (w_rd_data),
    .o_rd_valid (out_valid),
    .o_full     (full),
    .o_empty    (empty)
  );

  assign rtib_out = rtib_pack(w_rd_data[ENT_W-1:DATA_LEN],
                              64'(w_rd_data[DATA_LEN-1:0]));

  // Change detector history and error pulses / dropped-event capture.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_prev_data         <= '0;
      overflow_error      <= 1'b0;
      underflow_error     <= 1'b0;
      overflow_error_data <= '0;
    end else if (flush) begin
      r_prev_data         <= w_sample;
      overflow_error      <= 1'b0;
      underflow_error     <= 1'b0;
      overflow_error_data <= '0;
    end else begin
      r_prev_data     <= w_sample;
      overflow_error  <= w_overflow;
      underflow_error <= w_underflow;
      if (w_overflow)
        overflow_error_data <= rtib_pack(w_stamp, 64'(w_sample));
    end
  end

endmodule

// File: tb/tb_rtib_core.sv
// tb_rtib_core: directed stimulus with a scoreboard queue; a negedge monitor
// checks every out_valid word against the queued expectation.
module tb_rtib_core;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         auto_start = 1'b0;
  logic         flush = 1'b0;
  logic [7:0]   data_in = 8'h00;
  logic [63:0]  counter = 64'd0;
  logic         read = 1'b0;
  logic [127:0] rtib_out;
  logic         out_valid;
  logic         overflow_error;
  logic [127:0] overflow_error_data;
  logic         underflow_error;
  logic         full;
  logic         empty;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_q[$];   // words the monitor must see on out_valid
  logic [127:0] model[$];   // expected FIFO contents
  logic [127:0] last_word;

  rtib_core dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .auto_start          (auto_start),
    .flush               (flush),
    .data_in             (data_in),
    .counter             (counter),
    .read                (read),
    .rtib_out            (rtib_out),
    .out_valid           (out_valid),
    .overflow_error      (overflow_error),
    .overflow_error_data (overflow_error_data),
    .underflow_error     (underflow_error),
    .full                (full),
    .empty               (empty)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ent(input logic [63:0] ts, input logic [7:0] d);
    return {ts, 56'h0, d};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    counter = counter + 64'd1;
  endtask

  // Event at the current counter; remembered in the FIFO model.
  task automatic ev(input logic [7:0] d);
    data_in = d;
    model.push_back(ent(counter, d));
    step();
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {127'd0, out_valid}, 128'd0);
      end else begin
        chk("rtib_out", rtib_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) step();
    chk("rst_rtib_out", rtib_out, 128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_empty", {127'd0, empty}, 128'd1);
    chk("rst_full", {127'd0, full}, 128'd0);
    chk("rst_ovf", {127'd0, overflow_error}, 128'd0);
    chk("rst_udf", {127'd0, underflow_error}, 128'd0);
    chk("rst_ovf_data", overflow_error_data, 128'd0);
    reset_n = 1'b1;
    repeat (3) step();

    // Single event at counter 100, then read it back.
    auto_start = 1'b1;
    counter = 64'd100;
    ev(8'h05);
    chk("first_write_not_empty", {127'd0, empty}, 128'd0);
    read = 1'b1;
    exp_q.push_back(model.pop_front());
    step();
    read = 1'b0;
    chk("first_read_empty", {127'd0, empty}, 128'd1);

    // Held input: no events.
    repeat (50) step();
    chk("held_empty", {127'd0, empty}, 128'd1);

    // Fill to threshold.
    for (int i = 0; i < 1000; i++) ev((i % 2 == 0) ? 8'h10 : 8'h20);
    chk("fill_full", {127'd0, full}, 128'd1);

    // 1001st event dropped.
    counter = 64'd2000;
    data_in = 8'hAA;
    step();
    chk("ovf_pulse", {127'd0, overflow_error}, 128'd1);
    chk("ovf_data", overflow_error_data, ent(64'd2000, 8'hAA));
    chk("ovf_still_full", {127'd0, full}, 128'd1);
    step();
    chk("ovf_pulse_end", {127'd0, overflow_error}, 128'd0);
    chk("ovf_data_hold", overflow_error_data, ent(64'd2000, 8'hAA));

    // Event + pop while full: full seen before pop, event dropped.
    counter = 64'd3000;
    data_in = 8'hBB;
    read = 1'b1;
    exp_q.push_back(model.pop_front());
    step();
    chk("ovf_with_pop", {127'd0, overflow_error}, 128'd1);
    chk("ovf_with_pop_data", overflow_error_data, ent(64'd3000, 8'hBB));
    chk("pop_leaves_999", {127'd0, full}, 128'd0);

    // Write + pop at 999: occupancy unchanged.
    exp_q.push_back(model.pop_front());
    ev(8'hCC);
    read = 1'b0;
    chk("wr_pop_999", {127'd0, full}, 128'd0);
    ev(8'hDD);
    chk("refill_full", {127'd0, full}, 128'd1);

    // Drain everything.
    read = 1'b1;
    while (model.size() > 0) begin
      last_word = model.pop_front();
      exp_q.push_back(last_word);
      step();
    end
    chk("drain_empty", {127'd0, empty}, 128'd1);
    chk("drain_last", last_word[7:0], 128'hDD);

    // Read while empty.
    step();
    chk("udf_pulse", {127'd0, underflow_error}, 128'd1);
    chk("udf_no_valid", {127'd0, out_valid}, 128'd0);
    chk("udf_out_hold", rtib_out, last_word);
    read = 1'b0;
    step();
    chk("udf_pulse_end", {127'd0, underflow_error}, 128'd0);

    // Flush with a same-cycle event.
    ev(8'h01);
    ev(8'h02);
    ev(8'h03);
    model.delete();
    flush = 1'b1;
    data_in = 8'h04;
    step();
    flush = 1'b0;
    chk("flush_empty", {127'd0, empty}, 128'd1);
    chk("flush_out_zero", rtib_out, 128'd0);
    chk("flush_ovd_zero", overflow_error_data, 128'd0);
    chk("flush_ovf", {127'd0, overflow_error}, 128'd0);
    step();
    chk("flush_prev_tracked", {127'd0, empty}, 128'd1);
    read = 1'b1;
    step();
    read = 1'b0;
    chk("flush_udf", {127'd0, underflow_error}, 128'd1);
    chk("flush_read_out", rtib_out, 128'd0);
    chk("flush_read_valid", {127'd0, out_valid}, 128'd0);

    // Reset during a read burst.
    ev(8'h31);
    ev(8'h32);
    ev(8'h33);
    ev(8'h34);
    read = 1'b1;
    exp_q.push_back(model.pop_front());
    step();
    exp_q.push_back(model.pop_front());
    step();
    reset_n = 1'b0;
    data_in = 8'h00;
    #1;
    exp_q.delete();
    model.delete();
    chk("mid_rst_out", rtib_out, 128'd0);
    chk("mid_rst_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_empty", {127'd0, empty}, 128'd1);
    chk("mid_rst_full", {127'd0, full}, 128'd0);
    step();
    reset_n = 1'b1;
    step();
    step();
    chk("post_rst_empty", {127'd0, empty}, 128'd1);
    chk("post_rst_out", rtib_out, 128'd0);
    step();
    chk("post_rst_udf", {127'd0, underflow_error}, 128'd1);
    chk("post_rst_valid", {127'd0, out_valid}, 128'd0);
    chk("post_rst_no_stale", rtib_out, 128'd0);
    read = 1'b0;
    step();
    step();

    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
